// File: rtl/z80_step_ctrl_if.sv
// Z80 bus taps plus debug-host controls/status for the step controller.
// master = CPU socket / host side, slave = step controller.
interface z80_step_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  // Z80 bus
  logic              M1_B;
  logic              MREQ_B;
  logic              IOREQ_B;
  logic [ADDR_W-1:0] A;
  logic              READY;
  // debug host
  logic              step_en;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic              step_go;
  logic              halted;
  logic [ADDR_W-1:0] halt_addr;
  logic              bp_hit;
  logic [CNT_W-1:0]  step_cnt;

  modport master (
    output M1_B, MREQ_B, IOREQ_B, A, step_en, bp_en, bp_addr, step_go,
    input  READY, halted, halt_addr, bp_hit, step_cnt
  );

  modport slave (
    input  M1_B, MREQ_B, IOREQ_B, A, step_en, bp_en, bp_addr, step_go,
    output READY, halted, halt_addr, bp_hit, step_cnt
  );
endinterface

// File: rtl/z80_step_ctrl.sv
// Z80 single-step / breakpoint controller. Holds the CPU in wait states at
// opcode fetch by pulling READY low, and lets it go one instruction at a
// time on step_go.
module z80_step_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic            CLK,
  input  logic            RESET_B,
  z80_step_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_REL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              bp;
  } halt_rec_t;

  state_t            state, state_d;
  halt_rec_t         rec_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              fetch, match, halt_cond;
  logic              cap, rel;

  // Opcode fetch seen at T2 rise; IOREQ low marks interrupt-acknowledge M1.
  assign fetch     = ~bus.M1_B & ~bus.MREQ_B & bus.IOREQ_B;
  assign match     = bus.bp_en & (bus.A == bus.bp_addr);
  assign halt_cond = fetch & (bus.step_en | match);

  // State register; async reset frees the CPU at once.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) state <= S_RUN;
    else          state <= state_d;
  end

  // Next state: halt wins over step_go in RUN; REL waits for M1 to end so
  // the just-released fetch cannot re-halt.
  always_comb begin
    state_d = state;
    cap     = 1'b0;
    rel     = 1'b0;
    case (state)
      S_RUN: begin
        if (halt_cond) begin
          state_d = S_HALT;
          cap     = 1'b1;
        end
      end
      S_HALT: begin
        if (bus.step_go) begin
          state_d = S_REL;
          rel     = 1'b1;
        end
      end
      S_REL: begin
        if (bus.M1_B) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Halt record captured on entry to HALT; held until the next halt.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B)  rec_q <= '0;
    else if (cap)  rec_q <= '{addr: bus.A, bp: match};
  end

  // Release counter, wraps naturally.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B)  cnt_q <= '0;
    else if (rel)  cnt_q <= cnt_q + CNT_W'(1);
  end

  // READY/halted decode straight from the state flop: glitch-free and
  // forced high by reset without a clock.
  assign bus.READY     = (state != S_HALT);
  assign bus.halted    = (state == S_HALT);
  assign bus.halt_addr = rec_q.addr;
  assign bus.bp_hit    = rec_q.bp;
  assign bus.step_cnt  = cnt_q;

endmodule

// File: tb/tb_z80_step_ctrl.sv
// Bench for z80_step_ctrl: bus-cycle driver tasks, expected halts queued
// when a fetch is driven and popped when the controller halts.
module tb_z80_step_ctrl;

  typedef struct packed {
    logic [15:0] addr;
    logic        bp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  z80_step_ctrl_if #(.ADDR_W(16), .CNT_W(16)) bus ();
  z80_step_ctrl_if #(.ADDR_W(16), .CNT_W(4))  bus4 ();

  assign bus4.M1_B    = bus.M1_B;
  assign bus4.MREQ_B  = bus.MREQ_B;
  assign bus4.IOREQ_B = bus.IOREQ_B;
  assign bus4.A       = bus.A;
  assign bus4.step_en = bus.step_en;
  assign bus4.bp_en   = bus.bp_en;
  assign bus4.bp_addr = bus.bp_addr;
  assign bus4.step_go = bus.step_go;

  z80_step_ctrl #(.ADDR_W(16), .CNT_W(16)) dut  (.CLK(clk), .RESET_B(rst_n), .bus(bus));
  z80_step_ctrl #(.ADDR_W(16), .CNT_W(4))  dut4 (.CLK(clk), .RESET_B(rst_n), .bus(bus4));

  task automatic bus_idle();
    bus.M1_B = 1'b1; bus.MREQ_B = 1'b1; bus.IOREQ_B = 1'b1;
  endtask

  // One M1 cycle; if a halt is expected the bus is left held for release.
  task automatic do_fetch(input logic [15:0] addr, input logic iack);
    logic exp_halt;
    exp_t e;
    @(negedge clk);
    bus.A = addr; bus.M1_B = 1'b0;
    bus.MREQ_B  = iack;
    bus.IOREQ_B = ~iack;
    exp_halt = !iack && (bus.step_en || (bus.bp_en && addr == bus.bp_addr));
    if (exp_halt) exp_q.push_back('{addr: addr, bp: bus.bp_en && addr == bus.bp_addr});
    @(negedge clk);
    checks++;
    if (bus.halted !== exp_halt || bus.READY !== !exp_halt) begin
      errors++;
      $display("FAIL fetch_halt A=%h halted=%b READY=%b required halted=%b", addr, bus.halted, bus.READY, exp_halt);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (bus.halted === 1'b1) begin
        checks++;
        if (bus.halt_addr !== e.addr || bus.bp_hit !== e.bp) begin
          errors++;
          $display("FAIL halt_rec halt_addr=%h bp_hit=%b required %h %b", bus.halt_addr, bus.bp_hit, e.addr, e.bp);
        end
      end
    end
    if (!exp_halt) begin
      bus_idle();
      @(negedge clk);
    end
  endtask

  // step_go pulse, then M1 still low for a cycle (must not re-halt), then bus idle.
  task automatic do_release();
    @(negedge clk); bus.step_go = 1'b1;
    @(negedge clk); bus.step_go = 1'b0;
    exp_cnt++;
    checks++;
    if (bus.READY !== 1'b1 || bus.halted !== 1'b0 || bus.step_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL release READY=%b halted=%b step_cnt=%0d required 1 0 %0d", bus.READY, bus.halted, bus.step_cnt, exp_cnt);
    end
    @(negedge clk);
    checks++;
    if (bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL rel_no_rehalt halted=%b required 0", bus.halted);
    end
    bus_idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.READY !== 1'b1 || bus.halted !== 1'b0 || bus.halt_addr !== 16'h0 ||
        bus.bp_hit !== 1'b0 || bus.step_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset READY=%b halted=%b halt_addr=%h bp_hit=%b step_cnt=%0d required 1 0 0000 0 0",
               bus.READY, bus.halted, bus.halt_addr, bus.bp_hit, bus.step_cnt);
    end
    rst_n = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
  endtask

  task automatic test_free_run();
    bus.step_en = 1'b0; bus.bp_en = 1'b0;
    for (int i = 0; i < 20; i++) do_fetch(16'(i), 1'b0);
    checks++;
    if (bus.step_cnt !== 16'h0) begin
      errors++;
      $display("FAIL free_run_cnt step_cnt=%0d required 0", bus.step_cnt);
    end
  endtask

  task automatic test_step();
    bus.step_en = 1'b1;
    do_fetch(16'h1234, 1'b0);
    // step_en dropped while halted must not release
    bus.step_en = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL hold_on_step_en_drop halted=%b required 1", bus.halted);
    end
    bus.step_en = 1'b1;
    do_release();
    do_fetch(16'h1235, 1'b0);
    do_release();
    bus.step_en = 1'b0;
  endtask

  task automatic test_breakpoint();
    bus.step_en = 1'b0; bus.bp_en = 1'b1; bus.bp_addr = 16'h0038;
    for (int a = 16'h30; a <= 16'h40; a++) begin
      do_fetch(16'(a), 1'b0);
      if (a == 16'h38) do_release();
    end
    do_fetch(16'h0038, 1'b1);
    checks++;
    if (bus.bp_hit !== 1'b1 || bus.halt_addr !== 16'h0038) begin
      errors++;
      $display("FAIL bp_hold bp_hit=%b halt_addr=%h required 1 0038", bus.bp_hit, bus.halt_addr);
    end
  endtask

  task automatic test_step_and_bp();
    bus.step_en = 1'b1; bus.bp_en = 1'b1; bus.bp_addr = 16'h0100;
    bus.step_go = 1'b1;
    do_fetch(16'h0100, 1'b0);
    bus.step_go = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.halted !== 1'b1 || bus.step_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL go_on_halt_edge halted=%b step_cnt=%0d required 1 %0d", bus.halted, bus.step_cnt, exp_cnt);
    end
    do_release();
    bus.step_en = 1'b0; bus.bp_en = 1'b0;
    do_fetch(16'h0101, 1'b0);
  endtask

  task automatic test_async_reset();
    bus.step_en = 1'b1;
    do_fetch(16'h8000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.READY !== 1'b1 || bus.halted !== 1'b0 || bus.step_cnt !== 16'h0) begin
      errors++;
      $display("FAIL async_reset READY=%b halted=%b step_cnt=%0d required 1 0 0", bus.READY, bus.halted, bus.step_cnt);
    end
    bus_idle();
    bus.step_en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    bus.step_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      do_fetch(16'h2000 + 16'(i), 1'b0);
      do_release();
      checks++;
      if (bus4.step_cnt !== exp_cnt[3:0]) begin
        errors++;
        $display("FAIL cnt4 step_cnt=%0d required %0d", bus4.step_cnt, exp_cnt[3:0]);
      end
    end
    checks++;
    if (bus4.step_cnt !== 4'd1 || bus.step_cnt !== 16'd17) begin
      errors++;
      $display("FAIL wrap cnt4=%0d cnt16=%0d required 1 17", bus4.step_cnt, bus.step_cnt);
    end
    bus.step_en = 1'b0;
  endtask

  initial begin
    bus_idle();
    bus.A = '0; bus.step_en = 1'b0; bus.bp_en = 1'b0;
    bus.bp_addr = '0; bus.step_go = 1'b0;
    test_reset();
    test_free_run();
    test_step();
    test_breakpoint();
    test_step_and_bp();
    test_async_reset();
    test_wrap();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left entries=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
